// File: rtl/tff_cnt_pkg.sv
// Shared constants for the toggle-flip-flop modulo counter.
//   DEFAULT_WIDTH / DEFAULT_MOD : default counter width and modulus
//   DIR_UP / DIR_DOWN           : encoding of the direction input
package tff_cnt_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_MOD   = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle of the modulo counter.
//   en, load, d, up (only with TFF_MOD_COUNTER_DOWN_EN) : controls from master
//   q, tc, ovf, t                                        : status from counter
// Optional feature macro: TFF_MOD_COUNTER_DOWN_EN adds the up signal.
interface tff_mod_counter_if #(
    parameter int unsigned WIDTH = tff_cnt_pkg::DEFAULT_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
`ifdef TFF_MOD_COUNTER_DOWN_EN
    logic             up;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic [WIDTH-1:0] t;

`ifdef TFF_MOD_COUNTER_DOWN_EN
    modport master (output en, load, d, up, input q, tc, ovf, t);
    modport slave  (input en, load, d, up, output q, tc, ovf, t);
`else
    modport master (output en, load, d, input q, tc, ovf, t);
    modport slave  (input en, load, d, output q, tc, ovf, t);
`endif

endinterface

// File: rtl/t_ff_cell.sv
// Single T flip-flop storage cell.
//   clk : rising-edge clock
//   rst : synchronous active-high clear
//   t   : toggle enable
//   q   : stored bit
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD counter built from T flip-flop cells.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of tff_mod_counter_if (en, load, d, [up], q, tc, ovf, t)
// Priority rst > load > en. Optional feature macro TFF_MOD_COUNTER_DOWN_EN
// enables down counting via bus.up; otherwise the counter counts up only.
module tff_mod_counter
    import tff_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned MOD   = DEFAULT_MOD
) (
    input  logic                clk,
    input  logic                rst,
    tff_mod_counter_if.slave    bus
);

    // Modulus is one bit wider so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] d_eff;
    logic [WIDTH-1:0] term;
    logic             q_ge_mod;
    logic             count_up;
    logic             wrap;
    logic             ovf_r;

`ifdef TFF_MOD_COUNTER_DOWN_EN
    assign count_up = (bus.up == DIR_UP);
`else
    assign count_up = DIR_UP;
`endif

    assign q_ge_mod = ({1'b0, q} >= MOD_W);
    assign d_eff    = ({1'b0, bus.d} < MOD_W) ? bus.d : '0;
    assign term     = count_up ? MAX_V : '0;

    always_comb begin
        next_q = q;
        wrap   = 1'b0;
        if (rst) begin
            next_q = '0;
        end else if (bus.load) begin
            next_q = d_eff;
        end else if (bus.en) begin
            if (count_up) begin
                if (q == MAX_V) begin
                    next_q = '0;
                    wrap   = 1'b1;
                end else if (q_ge_mod) begin
                    next_q = '0;
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    next_q = MAX_V;
                    wrap   = 1'b1;
                end else if (q_ge_mod) begin
                    next_q = '0;
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

    // Every state change, including load, is expressed as a toggle mask.
    assign t_vec = q ^ next_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (bus.load) begin
            ovf_r <= 1'b0;
        end else if (wrap) begin
            ovf_r <= 1'b1;
        end
    end

    assign bus.q   = q;
    assign bus.t   = t_vec;
    assign bus.tc  = bus.en & ~bus.load & (q == term);
    assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter (WIDTH=4, MOD=10). The driver pushes
// the expected per-cycle outputs computed by an arithmetic model; a monitor
// pops and compares them on the falling edge.
module tb_tff_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       ovf;
        logic       tc;
        logic [3:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tff_mod_counter_if #(.WIDTH(W)) ifc ();

    tff_mod_counter #(.WIDTH(W), .MOD(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   q_m      = 0;
    int   ovf_m    = 0;
    bit   model_ok = 1'b0;

    task automatic step(input string nm, input bit r, input bit e, input bit l,
                        input int dv, input bit u);
        exp_t x;
        int   nq;
        int   novf;
        bit   dir_up;
        @(posedge clk);
        #2;
        rst      = r;
        ifc.en   = e;
        ifc.load = l;
        ifc.d    = 4'(dv);
`ifdef TFF_MOD_COUNTER_DOWN_EN
        ifc.up   = u;
        dir_up   = u;
`else
        dir_up   = 1'b1;
        if (u) dir_up = 1'b1;
`endif
        if (!model_ok) begin
            if (r) begin
                model_ok = 1'b1;
                q_m      = 0;
                ovf_m    = 0;
            end
            return;
        end
        nq   = q_m;
        novf = ovf_m;
        if (r) begin
            nq   = 0;
            novf = 0;
        end else if (l) begin
            nq   = (dv < M) ? dv : 0;
            novf = 0;
        end else if (e) begin
            if (dir_up) begin
                if (q_m == M - 1) begin
                    nq = 0; novf = 1;
                end else begin
                    nq = (q_m + 1) % M;
                end
            end else begin
                if (q_m == 0) begin
                    nq = M - 1; novf = 1;
                end else if (q_m >= M) begin
                    nq = 0;
                end else begin
                    nq = q_m - 1;
                end
            end
        end
        x.name = nm;
        x.q    = 4'(q_m);
        x.ovf  = (ovf_m != 0);
        x.tc   = e && !l && (q_m == (dir_up ? M - 1 : 0));
        x.t    = 4'(q_m ^ nq);
        exp_q.push_back(x);
        q_m   = nq;
        ovf_m = novf;
    endtask

    // Monitor: one expectation per clock cycle, sampled mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (ifc.q !== x.q) begin
                    failures++;
                    $display("FAIL %s q: got %0d expected %0d", x.name, ifc.q, x.q);
                end
                checks++;
                if (ifc.ovf !== x.ovf) begin
                    failures++;
                    $display("FAIL %s ovf: got %0b expected %0b", x.name, ifc.ovf, x.ovf);
                end
                checks++;
                if (ifc.tc !== x.tc) begin
                    failures++;
                    $display("FAIL %s tc: got %0b expected %0b", x.name, ifc.tc, x.tc);
                end
                checks++;
                if (ifc.t !== x.t) begin
                    failures++;
                    $display("FAIL %s t: got %h expected %h", x.name, ifc.t, x.t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.en   = 1'b1;
        ifc.load = 1'b1;
        ifc.d    = 4'd5;
`ifdef TFF_MOD_COUNTER_DOWN_EN
        ifc.up   = 1'b1;
`endif
        // Reset with en and load active.
        step("reset", 1, 1, 1, 5, 1);
        step("reset", 1, 1, 1, 5, 1);
        // Up count through a full wrap.
        for (int i = 0; i < 10; i++) step("up_wrap", 0, 1, 0, 0, 1);
        step("after_wrap", 0, 1, 0, 0, 1);
        // Loads: in range, then clamped.
        step("load7", 0, 1, 1, 7, 1);
        step("load12", 0, 1, 1, 12, 1);
        step("after_load12", 0, 0, 0, 0, 1);
        // Hold at 4.
        step("load4", 0, 1, 1, 4, 1);
        for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 9, 1);
`ifdef TFF_MOD_COUNTER_DOWN_EN
        // Down wrap from 1.
        step("load1", 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step("down_wrap", 0, 1, 0, 0, 0);
`endif
        // Reset mid-count.
        step("load6", 0, 0, 1, 6, 1);
        step("rst_mid", 1, 1, 0, 3, 1);
        for (int i = 0; i < 4; i++) step("resume", 0, 1, 0, 0, 1);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 12),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1));
        end
        step("final", 0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
